// File: rtl/cordic_engine_if.sv
// Handshake and operand/result bundle for cordic_engine.
// The master side presents operations and consumes results; the engine is the slave.
interface cordic_engine_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] z_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] z_out;

  modport master (
    output in_valid, mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode,
// no gain compensation. Results are the working registers, held through DONE and IDLE.
module cordic_engine #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 29,
  parameter int ITER  = 16
) (
  input logic            clk,
  input logic            rst_n,
  cordic_engine_if.slave bus
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST_I = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  // atan(2^-i) at 62 fraction bits (pi/4 for i = 0, odd power series otherwise), rounded to FRAC.
  function automatic longint atan_q(input int i);
    longint acc;
    longint term;
    if (i == 32'sd0) begin
      acc = 64'sh3243F6A8885A308D;
    end else begin
      acc = 64'sd0;
      for (int k = 1; i * k < 32'sd62; k += 2) begin
        term = (64'sd1 <<< 62) >>> (i * k);
        term = term / k;
        acc  = ((k % 4) == 32'sd1) ? acc + term : acc - term;
      end
    end
    return (acc + (64'sd1 <<< (61 - FRAC))) >>> (62 - FRAC);
  endfunction

  logic [WIDTH-1:0] atan_tab_s [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam longint ATAN_Q = atan_q(g);
    assign atan_tab_s[g] = ATAN_Q[WIDTH-1:0];
  end

  state_t                   state_r;
  state_t                   state_nx_s;
  logic                     accept_s;
  logic                     step_s;
  logic                     mode_r;
  logic [CW-1:0]            i_r;
  logic signed [WIDTH-1:0]  x_r;
  logic signed [WIDTH-1:0]  y_r;
  logic signed [WIDTH-1:0]  z_r;
  logic signed [WIDTH-1:0]  x_nx_s;
  logic signed [WIDTH-1:0]  y_nx_s;
  logic signed [WIDTH-1:0]  z_nx_s;
  logic                     d_pos_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept_s   = 1'b1;
          state_nx_s = S_ITER;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ITER: begin
        step_s = 1'b1;
        if (i_r == LAST_I) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_ITER;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // One micro-rotation; d = +1 drives z towards zero (rotation) or y towards zero (vectoring).
  always_comb begin
    d_pos_s = mode_r ? y_r[WIDTH-1] : ~z_r[WIDTH-1];
    if (d_pos_s) begin
      x_nx_s = x_r - (y_r >>> i_r);
      y_nx_s = y_r + (x_r >>> i_r);
      z_nx_s = z_r - $signed(atan_tab_s[i_r]);
    end else begin
      x_nx_s = x_r + (y_r >>> i_r);
      y_nx_s = y_r - (x_r >>> i_r);
      z_nx_s = z_r + $signed(atan_tab_s[i_r]);
    end
  end

  // Working registers double as the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
      i_r    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
    end else if (accept_s) begin
      mode_r <= bus.mode;
      i_r    <= '0;
      x_r    <= bus.x_in;
      y_r    <= bus.y_in;
      z_r    <= bus.z_in;
    end else if (step_s) begin
      mode_r <= mode_r;
      i_r    <= i_r + CW'(1);
      x_r    <= x_nx_s;
      y_r    <= y_nx_s;
      z_r    <= z_nx_s;
    end else begin
      mode_r <= mode_r;
      i_r    <= i_r;
      x_r    <= x_r;
      y_r    <= y_r;
      z_r    <= z_r;
    end
  end

  // Ready is masked by rst_n so it drops at once on reset and rises at release.
  assign bus.in_ready  = rst_n & (state_r == S_IDLE);
  assign bus.out_valid = (state_r == S_DONE);
  assign bus.x_out     = x_r;
  assign bus.y_out     = y_r;
  assign bus.z_out     = z_r;
endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine: default build and a 24/21/20 build side by side,
// checked against accuracy targets and a bit-exact reference model.
module tb_cordic_engine;
  localparam int W0 = 32, F0 = 29, I0 = 16;
  localparam int W1 = 24, F1 = 21, I1 = 20;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cordic_engine_if #(.WIDTH(W0)) b0 ();
  cordic_engine_if #(.WIDTH(W1)) b1 ();

  cordic_engine #(.WIDTH(W0), .FRAC(F0), .ITER(I0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  cordic_engine #(.WIDTH(W1), .FRAC(F1), .ITER(I1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic m;
    real  x, y, z;
    real  ex, ey, ez;
  } vec_t;

  vec_t vt [4];

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input real act, input real exp);
    real diff;
    n_checks++;
    diff = act - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > 2.0 ** (-12)) begin
      n_errors++;
      $display("FAIL %s: got %f, expected %f (+/- 2^-12)", name, act, exp);
    end
  endtask

  function automatic longint to_fix(input real v, input int f);
    real s;
    s = v * (2.0 ** f);
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    else return -longint'($rtoi(-s + 0.5));
  endfunction

  function automatic real to_real(input longint v, input int f);
    return real'(v) / (2.0 ** f);
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  // Reference: textbook CORDIC on w-bit wrapped integers with an atan table from $atan.
  task automatic model(input int w, input int f, input int it, input logic m,
                       input longint xi, input longint yi, input longint zi,
                       output longint xo, output longint yo, output longint zo);
    longint x, y, z, xn, yn, a;
    logic   d;
    x = wrap(xi, w);
    y = wrap(yi, w);
    z = wrap(zi, w);
    for (int i = 0; i < it; i++) begin
      a  = longint'($rtoi($atan(2.0 ** (-i)) * (2.0 ** f) + 0.5));
      d  = m ? (y < 0) : (z >= 0);
      xn = d ? x - (y >>> i) : x + (y >>> i);
      yn = d ? y + (x >>> i) : y - (x >>> i);
      z  = wrap(d ? z - a : z + a, w);
      x  = wrap(xn, w);
      y  = wrap(yn, w);
    end
    xo = x;
    yo = y;
    zo = z;
  endtask

  function automatic logic valid_of(input int sel);
    return (sel == 0) ? b0.out_valid : b1.out_valid;
  endfunction

  // Present one operation, scramble the inputs during ITER, and wait for out_valid.
  task automatic run_op(input int sel, input logic m, input longint xi, input longint yi,
                        input longint zi, output longint xo, output longint yo,
                        output longint zo, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!((sel == 0) ? b0.in_ready : b1.in_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sel == 0) begin
      b0.mode = m; b0.x_in = xi[W0-1:0]; b0.y_in = yi[W0-1:0]; b0.z_in = zi[W0-1:0];
      b0.in_valid = 1'b1;
    end else begin
      b1.mode = m; b1.x_in = xi[W1-1:0]; b1.y_in = yi[W1-1:0]; b1.z_in = zi[W1-1:0];
      b1.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    b0.mode = ~m; b0.x_in = $urandom(); b0.y_in = $urandom(); b0.z_in = $urandom();
    b1.mode = ~m; b1.x_in = W1'($urandom()); b1.y_in = W1'($urandom()); b1.z_in = W1'($urandom());
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!valid_of(sel) && lat < 200);
    if (sel == 0) begin
      xo = longint'($signed(b0.x_out)); yo = longint'($signed(b0.y_out)); zo = longint'($signed(b0.z_out));
    end else begin
      xo = longint'($signed(b1.x_out)); yo = longint'($signed(b1.y_out)); zo = longint'($signed(b1.z_out));
    end
  endtask

  initial begin
    longint xo, yo, zo, mx, my, mz, xi, yi, zi, hx, hy, hz;
    int     lat, f, w, it;
    logic   m;
    real    r;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    b0.in_valid = 1'b0; b0.out_ready = 1'b1; b0.mode = 1'b0; b0.x_in = '0; b0.y_in = '0; b0.z_in = '0;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.mode = 1'b0; b1.x_in = '0; b1.y_in = '0; b1.z_in = '0;

    vt[0] = '{1'b0, 1.0, 0.0, 0.0,        1.646760, 0.0,       0.0};
    vt[1] = '{1'b0, 1.0, 0.0, 0.5235988,  1.426136, 0.823380,  0.0};
    vt[2] = '{1'b0, 1.0, 0.0, -0.5235988, 1.426136, -0.823380, 0.0};
    vt[3] = '{1'b1, 1.0, 1.0, 0.0,        2.328873, 0.0,       0.785398};

    // Reset state
    #12;
    check_eq("rst in_ready", longint'(b0.in_ready), 0);
    check_eq("rst out_valid", longint'(b0.out_valid), 0);
    check_eq("rst x_out", longint'(b0.x_out), 0);
    check_eq("rst in_ready w24", longint'(b1.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("release in_ready", longint'(b0.in_ready), 1);
    check_eq("release in_ready w24", longint'(b1.in_ready), 1);

    // Directed accuracy vectors on both builds
    for (int sel = 0; sel < 2; sel++) begin
      f  = (sel == 0) ? F0 : F1;
      w  = (sel == 0) ? W0 : W1;
      it = (sel == 0) ? I0 : I1;
      for (int v = 0; v < 4; v++) begin
        xi = to_fix(vt[v].x, f); yi = to_fix(vt[v].y, f); zi = to_fix(vt[v].z, f);
        run_op(sel, vt[v].m, xi, yi, zi, xo, yo, zo, lat);
        check_eq($sformatf("vec%0d/%0d latency", v, sel), lat, it);
        check_tol($sformatf("vec%0d/%0d x", v, sel), to_real(xo, f), vt[v].ex);
        check_tol($sformatf("vec%0d/%0d y", v, sel), to_real(yo, f), vt[v].ey);
        check_tol($sformatf("vec%0d/%0d z", v, sel), to_real(zo, f), vt[v].ez);
        model(w, f, it, vt[v].m, xi, yi, zi, mx, my, mz);
        check_eq($sformatf("vec%0d/%0d model x", v, sel), xo, mx);
        check_eq($sformatf("vec%0d/%0d model y", v, sel), yo, my);
        check_eq($sformatf("vec%0d/%0d model z", v, sel), zo, mz);
      end
    end

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      int sel;
      sel = n % 2;
      f  = (sel == 0) ? F0 : F1;
      w  = (sel == 0) ? W0 : W1;
      it = (sel == 0) ? I0 : I1;
      m  = 1'($urandom_range(0, 1));
      r  = real'($urandom_range(0, 1000000)) / 1.0e6;
      xi = m ? to_fix(0.05 + 0.95 * r, f) : to_fix(-1.0 + 2.0 * r, f);
      r  = real'($urandom_range(0, 1000000)) / 1.0e6;
      yi = to_fix(-1.0 + 2.0 * r, f);
      r  = real'($urandom_range(0, 1000000)) / 1.0e6;
      zi = m ? to_fix(-0.5 + r, f) : to_fix(-1.7 + 3.4 * r, f);
      run_op(sel, m, xi, yi, zi, xo, yo, zo, lat);
      model(w, f, it, m, xi, yi, zi, mx, my, mz);
      check_eq($sformatf("rnd%0d latency", n), lat, it);
      check_eq($sformatf("rnd%0d x", n), xo, mx);
      check_eq($sformatf("rnd%0d y", n), yo, my);
      check_eq($sformatf("rnd%0d z", n), zo, mz);
    end

    // Backpressure: result held, in_valid ignored, no new operation
    b0.out_ready = 1'b0;
    xi = to_fix(1.0, F0);
    run_op(0, 1'b1, xi, xi, 64'sd0, hx, hy, hz, lat);
    check_eq("bp latency", lat, I0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b0.in_valid = 1'b1; b0.mode = 1'b0; b0.x_in = $urandom(); b0.y_in = $urandom(); b0.z_in = $urandom();
      @(posedge clk);
      #1;
      check_eq("bp out_valid", longint'(b0.out_valid), 1);
      check_eq("bp in_ready", longint'(b0.in_ready), 0);
      check_eq("bp x held", longint'($signed(b0.x_out)), hx);
      check_eq("bp y held", longint'($signed(b0.y_out)), hy);
      check_eq("bp z held", longint'($signed(b0.z_out)), hz);
    end
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp release out_valid", longint'(b0.out_valid), 0);
    check_eq("bp release in_ready", longint'(b0.in_ready), 1);
    check_eq("idle x held", longint'($signed(b0.x_out)), hx);
    @(posedge clk);
    #1;
    check_eq("idle no new op", longint'(b0.in_ready), 1);

    // Reset asserted at iteration 7, between edges
    @(negedge clk);
    b0.mode = 1'b0; b0.x_in = to_fix(1.0, F0); b0.y_in = '0; b0.z_in = '0;
    b0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst out_valid", longint'(b0.out_valid), 0);
    check_eq("midrst in_ready", longint'(b0.in_ready), 0);
    check_eq("midrst x_out", longint'(b0.x_out), 0);
    check_eq("midrst y_out", longint'(b0.y_out), 0);
    check_eq("midrst z_out", longint'(b0.z_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst release in_ready", longint'(b0.in_ready), 1);
    run_op(0, 1'b0, to_fix(1.0, F0), 64'sd0, 64'sd0, xo, yo, zo, lat);
    check_eq("post-rst latency", lat, I0);
    check_tol("post-rst x", to_real(xo, F0), 1.646760);
    check_tol("post-rst y", to_real(yo, F0), 0.0);
    check_tol("post-rst z", to_real(zo, F0), 0.0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cordic_engine.md
CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data/angle word width, signed two's complement.
REQ-002 SHALL have parameter FRAC, default 29: fraction bits. 3.29 format by default, so 1.0 = 2^29.
REQ-003 SHALL have parameter ITER, default 16: micro-rotations per operation, legal range 1..WIDTH-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operands and mode are presented.
REQ-007 SHALL have port in_ready, output, 1 bit: engine can accept an operation.
REQ-008 SHALL have port mode, input, 1 bit: 0 = rotation, 1 = vectoring.
REQ-009 SHALL have ports x_in, y_in and z_in, input, WIDTH bits each: initial X, Y and angle Z (radians).
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have ports x_out, y_out and z_out, output, WIDTH bits each: result X, Y and Z.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, ITER and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-015 SHALL accept an operation on a rising edge when IDLE, in_valid = 1 and in_ready = 1. On that edge it loads x_in, y_in, z_in and mode, clears the iteration counter i, and enters ITER.
REQ-016 SHALL perform one micro-rotation per cycle in ITER, for i = 0..ITER-1, using all-registered arithmetic:
- x' = x - d*(y>>>i)
- y' = y + d*(x>>>i)
- z' = z - d*atan_i
REQ-017 SHALL select the rotation direction as follows:
- rotation mode: d = +1 if z >= 0, else -1.
- vectoring mode: d = +1 if y < 0, else -1.
REQ-018 SHALL use arithmetic (sign-preserving) shifts.
REQ-019 SHALL wrap add/sub results modulo 2^WIDTH, with no saturation.
REQ-020 SHALL take atan_i = atan(2^-i) in FRAC-bit radians, rounded to nearest, from a constant table fixed at elaboration for the given FRAC and ITER.
REQ-021 SHALL NOT compensate gain. Outputs carry the CORDIC gain K (≈1.646760 for ITER ≥ 16).
REQ-022 SHALL enter DONE on the edge that completes iteration ITER-1. out_valid therefore rises exactly ITER clock edges after the accepting edge.
REQ-023 SHALL hold x_out, y_out and z_out stable while out_valid = 1. Outputs are undefined-but-deterministic (working registers) in ITER and hold the last result in IDLE.
REQ-024 SHALL leave DONE for IDLE on an edge with out_ready = 1. Throughput is one operation per ITER+2 cycles minimum.
REQ-025 SHALL keep out_valid asserted indefinitely while out_ready = 0, with outputs unchanged.
REQ-026 SHALL ignore in_valid when not in IDLE. Operands are neither latched nor queued.
REQ-027 SHALL sample mode and operands only at accept; changes during ITER or DONE have no effect.
REQ-028 SHALL guarantee convergence only for the following legal domains; out-of-domain results are unspecified but SHALL still complete in the same latency:
- rotation: |z_in| ≤ 1.7432 rad.
- vectoring: x_in > 0.
- both modes: |x|,|y| ≤ 2^(WIDTH-FRAC-1)/(2K) to avoid wrap.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force state = IDLE, i = 0 and x_out = y_out = z_out = 0, regardless of the clock.
REQ-030 SHALL force out_valid = 0 and in_ready = 0 while rst_n = 0.
REQ-031 SHALL drive in_ready = 1 from release of rst_n, with the first accept possible on the first rising edge after release.
REQ-032 SHALL discard any in-flight operation when rst_n is asserted mid-ITER or in DONE, with no partial result ever flagged valid.

Verification
REQ-033 SHALL cover: rotation, x_in = 1.0, y_in = 0, z_in = 0 -> x_out ≈ 1.646760, |y_out| ≤ 2^-12, |z_out| ≤ 2^-12. out_valid must rise exactly 16 edges after accept.
REQ-034 SHALL cover: rotation, x_in = 1.0, y_in = 0, z_in = ±0.5235988 -> x_out ≈ 1.426136, y_out ≈ ±0.823380, each within ±2^-12.
REQ-035 SHALL cover: vectoring, x_in = 1.0, y_in = 1.0, z_in = 0 -> x_out ≈ 2.328873, |y_out| ≤ 2^-12, z_out ≈ 0.785398 ± 2^-12.
REQ-036 SHALL cover backpressure: hold out_ready = 0 for 10 cycles after out_valid and pulse in_valid meanwhile -> outputs constant, in_ready = 0, no second operation started. Then out_ready = 1 gives IDLE the next cycle.
REQ-037 SHALL cover reset mid-operation: assert rst_n = 0 at iteration 7 between edges -> out_valid = 0 and outputs = 0 at once. After release, in_ready = 1 and the REQ-033 vector again yields the correct result.
REQ-038 SHALL cover parameter sweep: WIDTH = 24, FRAC = 21, ITER = 20 rerunning REQ-033 to REQ-035 -> latency 20 edges, results within ±2^-12.
